// File: rtl/tx_lane_striper.sv
// TX byte striper: buffers a low-aligned byte/K stream and stripes it across L lanes x W bytes,
// padding the last partial stripe with K23.7. Define TX_LANE_REVERSAL_EN to add lane_reverse.
module tx_lane_striper #(
  parameter  int LANESNUMBER  = 16,
  parameter  int MAXPIPEWIDTH = 32,
  localparam int IN_BYTES     = LANESNUMBER * MAXPIPEWIDTH / 8,
  localparam int DEPTH        = 2 * IN_BYTES,
  localparam int IN_CNT_W     = $clog2(IN_BYTES + 1)
) (
`ifdef TX_LANE_REVERSAL_EN
  input  logic                                  lane_reverse,
`endif
  input  logic                                  pclk,
  input  logic                                  reset_n,
  input  logic [2:0]                            lanes_sel,
  input  logic [1:0]                            width_sel,
  input  logic [8*IN_BYTES-1:0]                 in_data,
  input  logic [IN_BYTES-1:0]                   in_k,
  input  logic [IN_CNT_W-1:0]                   in_count,
  input  logic                                  in_valid,
  input  logic                                  in_end,
  output logic                                  in_ready,
  output logic [LANESNUMBER*MAXPIPEWIDTH-1:0]   tx_data,
  output logic [LANESNUMBER*MAXPIPEWIDTH/8-1:0] tx_datak,
  output logic [LANESNUMBER-1:0]                tx_datavalid,
  output logic                                  busy
);

  localparam int         MAXB      = MAXPIPEWIDTH / 8;
  localparam int         CNT_W     = $clog2(DEPTH + 1);
  localparam int         IDX_W     = $clog2(DEPTH);
  localparam int         IN_IDX_W  = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
  localparam logic [2:0] L_LOG_MAX = 3'($clog2(LANESNUMBER));
  localparam logic [1:0] W_LOG_MAX = 2'($clog2(MAXB));

  // Buffer entry: {K flag, data byte}. PAD is K23.7.
  typedef logic [8:0] entry_t;
  localparam entry_t PAD = 9'h1F7;

  entry_t                  buf_q [DEPTH];
  entry_t                  buf_d [DEPTH];
  entry_t                  in_ent [IN_BYTES];
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    pend_q, pend_d;
  logic [2:0]              l_log_q, l_log_d, l_req;
  logic [1:0]              w_log_q, w_log_d, w_req;
  logic                    rev_q, rev_d;
  logic                    busy_q, busy_d;
  logic [LANESNUMBER*MAXPIPEWIDTH-1:0] tx_data_q, tx_data_d;
  logic [LANESNUMBER*MAXB-1:0]         tx_datak_q, tx_datak_d;
  logic [LANESNUMBER-1:0]              tx_valid_q, tx_valid_d;

  logic                    idle, push, full, pad, emit;
  logic [2:0]              stripe_log;
  logic [CNT_W-1:0]        stripe_sz, pop_amt, push_cnt, rem;

  assign in_ready     = (count_q <= CNT_W'(DEPTH - IN_BYTES));
  assign busy         = busy_q;
  assign tx_data      = tx_data_q;
  assign tx_datak     = tx_datak_q;
  assign tx_datavalid = tx_valid_q;

  assign idle = (count_q == '0) && !pend_q;

  always_comb begin : p_unpack
    for (int j = 0; j < IN_BYTES; j++) begin
      in_ent[j] = {in_k[j], in_data[j*8 +: 8]};
    end
  end

  // Lane count and width only change while nothing is buffered or pending.
  always_comb begin : p_cfg
    l_req = (lanes_sel > L_LOG_MAX) ? L_LOG_MAX : lanes_sel;
    w_req = width_sel[1] ? 2'd2 : width_sel;
    if (w_req > W_LOG_MAX) w_req = W_LOG_MAX;
    l_log_d = idle ? l_req : l_log_q;
    w_log_d = idle ? w_req : w_log_q;
`ifdef TX_LANE_REVERSAL_EN
    rev_d   = idle ? lane_reverse : rev_q;
`else
    rev_d   = 1'b0;
`endif
  end

  always_comb begin : p_ctrl
    stripe_log = l_log_q + {1'b0, w_log_q};
    stripe_sz  = CNT_W'(1) << stripe_log;
    full       = (count_q >= stripe_sz);
    pad        = !full && pend_q && (count_q != '0);
    emit       = full || pad;
    pop_amt    = full ? stripe_sz : (pad ? count_q : '0);
    push       = in_valid && in_ready;
    push_cnt   = '0;
    if (push) begin
      push_cnt = (in_count > IN_CNT_W'(IN_BYTES)) ? CNT_W'(IN_BYTES) : CNT_W'(in_count);
    end
    rem     = count_q - pop_amt;
    count_d = rem + push_cnt;
    // A full stripe leaves the end pending; pad or empty-end clears it before a new end sets it.
    pend_d  = (pend_q && full) || (push && in_end);
    busy_d  = (count_d != '0) || pend_d;
  end

  // Shift out the popped bytes, then append the accepted beat behind the survivors.
  always_comb begin : p_buf_next
    int src;
    int off;
    for (int i = 0; i < DEPTH; i++) begin
      src = i + int'(pop_amt);
      off = i - int'(rem);
      if (off >= 0 && off < int'(push_cnt)) begin
        buf_d[i] = in_ent[IN_IDX_W'(off)];
      end else if (src < DEPTH) begin
        buf_d[i] = buf_q[IDX_W'(src)];
      end else begin
        buf_d[i] = '0;
      end
    end
  end

  // Physical lane p, lane byte b takes stripe byte b*L + logical lane.
  always_comb begin : p_stripe
    int     n_lanes;
    int     n_bytes;
    int     lg;
    int     k;
    entry_t ent;
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    tx_data_d  = '0;
    tx_datak_d = '0;
    tx_valid_d = '0;
    n_lanes    = 1 << l_log_q;
    n_bytes    = 1 << w_log_q;
    lg         = 0;
    k          = 0;
    ent        = '0;
    for (int p = 0; p < LANESNUMBER; p++) begin
      tx_valid_d[p] = emit && (p < n_lanes);
      for (int b = 0; b < MAXB; b++) begin
        if (emit && p < n_lanes && b < n_bytes) begin
          lg  = rev_q ? (n_lanes - 1 - p) : p;
          k   = b * n_lanes + lg;
          ent = (k < int'(count_q)) ? buf_q[IDX_W'(k)] : PAD;
          tx_data_d[p*MAXPIPEWIDTH + b*8 +: 8] = ent[7:0];
          tx_datak_d[p*MAXB + b]               = ent[8];
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      pend_q     <= 1'b0;
      l_log_q    <= '0;
      w_log_q    <= '0;
      rev_q      <= 1'b0;
      busy_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_datak_q <= '0;
      tx_valid_q <= '0;
    end else begin
      count_q    <= count_d;
      pend_q     <= pend_d;
      l_log_q    <= l_log_d;
      w_log_q    <= w_log_d;
      rev_q      <= rev_d;
      busy_q     <= busy_d;
      tx_data_q  <= tx_data_d;
      tx_datak_q <= tx_datak_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // NOTE: the byte store is not reset; count_q alone decides which entries are meaningful.
  always_ff @(posedge pclk) begin
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_tx_lane_striper.sv
// Randomized bench for tx_lane_striper against a queue-based reference model of the striping rules.
module tb_tx_lane_striper;

  localparam int LN    = 16;
  localparam int MW    = 32;
  localparam int MB    = MW / 8;
  localparam int IB    = LN * MW / 8;
  localparam int DEPTH = 2 * IB;
  localparam int DW    = LN * MW;
  localparam int KW    = LN * MB;
  localparam int CW    = $clog2(IB + 1);

  logic          pclk;
  logic          reset_n;
  logic [2:0]    lanes_sel;
  logic [1:0]    width_sel;
  logic [8*IB-1:0] in_data;
  logic [IB-1:0] in_k;
  logic [CW-1:0] in_count;
  logic          in_valid;
  logic          in_end;
  logic          in_ready;
  logic [DW-1:0] tx_data;
  logic [KW-1:0] tx_datak;
  logic [LN-1:0] tx_datavalid;
  logic          busy;
  logic          lane_reverse;

  tx_lane_striper #(.LANESNUMBER(LN), .MAXPIPEWIDTH(MW)) dut (
`ifdef TX_LANE_REVERSAL_EN
    .lane_reverse (lane_reverse),
`endif
    .pclk         (pclk),
    .reset_n      (reset_n),
    .lanes_sel    (lanes_sel),
    .width_sel    (width_sel),
    .in_data      (in_data),
    .in_k         (in_k),
    .in_count     (in_count),
    .in_valid     (in_valid),
    .in_end       (in_end),
    .in_ready     (in_ready),
    .tx_data      (tx_data),
    .tx_datak     (tx_datak),
    .tx_datavalid (tx_datavalid),
    .busy         (busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the buffer is a plain byte queue; stripes are cut from its head.
  logic [8:0]    mq[$];
  bit            m_pend;
  int            m_l, m_w;
  bit            m_rev;
  bit            m_acc;
  logic [DW-1:0] e_data;
  logic [KW-1:0] e_k;
  logic [LN-1:0] e_valid;
  bit            e_busy;

  function automatic int lanes_of(input logic [2:0] s);
    return (int'(s) > $clog2(LN)) ? LN : (1 << s);
  endfunction

  function automatic int width_of(input logic [1:0] s);
    int w;
    w = s[1] ? 4 : (1 << s);
    return (w > MB) ? MB : w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pend  = 1'b0;
    m_l     = 1;
    m_w     = 1;
    m_rev   = 1'b0;
    e_data  = '0;
    e_k     = '0;
    e_valid = '0;
    e_busy  = 1'b0;
  endtask

  task automatic model_edge();
    int         s, cnt, n, lane, pos, phys;
    bit         idle;
    logic [8:0] st[$];
    logic [8:0] e;
    s    = m_l * m_w;
    cnt  = mq.size();
    idle = (cnt == 0) && !m_pend;
    m_acc = in_valid && (cnt <= DEPTH - IB);
    e_data  = '0;
    e_k     = '0;
    e_valid = '0;
    if (cnt >= s) begin
      repeat (s) st.push_back(mq.pop_front());
    end else if (m_pend) begin
      while (mq.size() > 0) st.push_back(mq.pop_front());
      if (st.size() > 0) while (st.size() < s) st.push_back(9'h1F7);
      m_pend = 1'b0;
    end
    for (int k = 0; k < st.size(); k++) begin
      e    = st[k];
      lane = k % m_l;
      pos  = k / m_l;
      phys = m_rev ? (m_l - 1 - lane) : lane;
      e_data[phys*MW + pos*8 +: 8] = e[7:0];
      e_k[phys*MB + pos]           = e[8];
      e_valid[phys]                = 1'b1;
    end
    if (m_acc) begin
      n = (int'(in_count) > IB) ? IB : int'(in_count);
      for (int j = 0; j < n; j++) mq.push_back({in_k[j], in_data[j*8 +: 8]});
      if (in_end) m_pend = 1'b1;
    end
    if (idle) begin
      m_l = lanes_of(lanes_sel);
      m_w = width_of(width_sel);
`ifdef TX_LANE_REVERSAL_EN
      m_rev = lane_reverse;
`endif
    end
    e_busy = (mq.size() != 0) || m_pend;
  endtask

  // One clock: check in_ready, advance the model, take the edge, check registered outputs.
  task automatic cycle();
    check("in_ready", in_ready, (mq.size() <= DEPTH - IB));
    model_edge();
    @(posedge pclk);
    @(negedge pclk);
    check("tx_data", tx_data, e_data);
    check("tx_datak", tx_datak, e_k);
    check("tx_datavalid", tx_datavalid, e_valid);
    check("busy", busy, e_busy);
  endtask

  task automatic drive_beat(input int n, input logic [7:0] first, input bit endf);
    for (int j = 0; j < IB; j++) begin
      in_data[j*8 +: 8] = (j < n) ? 8'(first + j) : 8'h00;
    end
    in_k     = '0;
    in_count = CW'(n);
    in_end   = endf;
    in_valid = 1'b1;
  endtask

  task automatic random_beat(input bit endf);
    for (int j = 0; j < IB; j++) begin
      in_data[j*8 +: 8] = 8'($urandom);
      in_k[j]           = ($urandom_range(0, 7) == 0);
    end
    in_count = CW'($urandom_range(0, IB + 6));
    in_end   = endf;
    in_valid = 1'b1;
  endtask

  task automatic send_beat();
    int t = 0;
    do begin
      cycle();
      t++;
    end while (!m_acc && t < 300);
    check("accept_timeout", m_acc, 1);
    in_valid = 1'b0;
    in_end   = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((mq.size() != 0 || m_pend) && t < 600) begin
      cycle();
      t++;
    end
    check("drain_timeout", e_busy, 0);
    cycle();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    in_end   = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("rst_tx_data", tx_data, '0);
    check("rst_tx_datak", tx_datak, '0);
    check("rst_tx_datavalid", tx_datavalid, '0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge pclk);
    @(negedge pclk);
    reset_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n      = 1'b0;
    lanes_sel    = 3'd0;
    width_sel    = 2'd0;
    in_data      = '0;
    in_k         = '0;
    in_count     = '0;
    in_valid     = 1'b0;
    in_end       = 1'b0;
    lane_reverse = 1'b0;
    model_reset();
    repeat (2) @(negedge pclk);
    check("init_tx_data", tx_data, '0);
    check("init_tx_datavalid", tx_datavalid, '0);
    check("init_busy", busy, 0);
    check("init_in_ready", in_ready, 1);
    reset_n = 1'b1;

    // x16, width 4: bytes 0..127 in two full beats, no pad stripe.
    lanes_sel = 3'd4;
    width_sel = 2'd2;
    cycle();
    drive_beat(64, 8'h00, 1'b0);
    cycle();
    drive_beat(64, 8'h40, 1'b1);
    cycle();
    check("x16_lane0_s0", tx_data[31:0], 32'h3020_1000);
    in_valid = 1'b0;
    in_end   = 1'b0;
    cycle();
    check("x16_lane0_s1", tx_data[31:0], 32'h7060_5040);
    drain();
    check("x16_idle_busy", busy, 0);

    // x4, width 1: six bytes, second stripe padded on lanes 2..3.
    lanes_sel = 3'd2;
    width_sel = 2'd0;
    drive_beat(6, 8'hA0, 1'b1);
    send_beat();
    cycle();
    check("x4_s1_lanes", {tx_data[96 +: 8], tx_data[64 +: 8], tx_data[32 +: 8], tx_data[0 +: 8]}, 32'hA3A2_A1A0);
    cycle();
    check("x4_pad_valid", tx_datavalid, 16'h000F);
    check("x4_pad_k", tx_datak, 64'h0000_0000_0000_1100);
    check("x4_pad_data", {tx_data[96 +: 8], tx_data[64 +: 8], tx_data[32 +: 8], tx_data[0 +: 8]}, 32'hF7F7_A5A4);
    drain();

    // Backpressure at x1: five full beats (320 bytes) held on in_valid.
    lanes_sel = 3'd0;
    width_sel = 2'd0;
    for (int b = 0; b < 5; b++) begin
      drive_beat(64, 8'(b * 64), b == 4);
      send_beat();
    end
    drain();

    // lanes_sel changes while 40 bytes sit in the x16 buffer.
    lanes_sel = 3'd4;
    width_sel = 2'd2;
    drive_beat(40, 8'h10, 1'b0);
    send_beat();
    lanes_sel = 3'd2;
    repeat (3) cycle();
    drive_beat(0, 8'h00, 1'b1);
    send_beat();
    cycle();
    check("cfg_hold_valid", tx_datavalid, 16'hFFFF);
    drain();
    drive_beat(8, 8'hC0, 1'b1);
    send_beat();
    cycle();
    check("cfg_next_valid", tx_datavalid, 16'h000F);
    drain();

    // Reset with ~70 bytes buffered and an end pending.
    lanes_sel = 3'd0;
    width_sel = 2'd0;
    drive_beat(64, 8'h00, 1'b0);
    send_beat();
    drive_beat(8, 8'h80, 1'b1);
    send_beat();
    cycle();
    do_reset();
    lanes_sel = 3'd2;
    drive_beat(4, 8'h50, 1'b1);
    send_beat();
    cycle();
    check("post_rst_lane0", tx_data[7:0], 8'h50);
    drain();

`ifdef TX_LANE_REVERSAL_EN
    lanes_sel    = 3'd3;
    width_sel    = 2'd0;
    lane_reverse = 1'b1;
    drive_beat(8, 8'h00, 1'b1);
    send_beat();
    cycle();
    check("rev_lane7", tx_data[7*MW +: 8], 8'h00);
    check("rev_lane0", tx_data[7:0], 8'h07);
    drain();
`endif

    // Random transfers; configuration inputs may change while data is buffered.
    for (int t = 0; t < 60; t++) begin
      int nb;
      lanes_sel    = 3'($urandom_range(0, 7));
      width_sel    = 2'($urandom_range(0, 3));
      lane_reverse = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) cycle();
        random_beat(b == nb - 1);
        send_beat();
      end
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_lane_striper.md
# tx_lane_striper

Parametrised TX byte striper for the PCIe PHY transmit path. It sits between the data/ordered-set mux and the per-lane scramblers. It accepts a low-aligned byte stream with K flags through a ready/valid handshake and buffers it. It then stripes the bytes across a runtime-selected number of active lanes at a runtime-selected PIPE width, and pads the last partial stripe of a transfer with PAD (K23.7).

## Interface
- `LANESNUMBER`, default 16: physical lanes; power of two, 1..16.
- `MAXPIPEWIDTH`, default 32: maximum bits per lane per `pclk`; 8, 16 or 32.
- Derived: `IN_BYTES` = LANESNUMBER*MAXPIPEWIDTH/8.
- Derived: `DEPTH` = 2*IN_BYTES bytes of staging buffer.
- `pclk`  in  1  clock; all state on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `lanes_sel`  in  3  0=x1, 1=x2, 2=x4, 3=x8, 4=x16; values above log2(LANESNUMBER) clamp to LANESNUMBER.
- `width_sel`  in  2  0=1 byte, 1=2 bytes, 2/3=4 bytes per lane; clamps to MAXPIPEWIDTH/8.
- `in_data`  in  8*IN_BYTES  input bytes; byte 0 is in bits [7:0] and is the first in order.
- `in_k`  in  IN_BYTES  K flag per input byte.
- `in_count`  in  clog2(IN_BYTES+1)  number of valid low-aligned bytes; values above IN_BYTES clamp to IN_BYTES.
- `in_valid`  in  1  beat offered.
- `in_end`  in  1  beat is the last of a transfer; qualified by acceptance.
- `in_ready`  out  1  beat will be accepted.
- `tx_data`  out  LANESNUMBER*MAXPIPEWIDTH  lane i occupies slice [i*MAXPIPEWIDTH +: MAXPIPEWIDTH]; lane byte 0 is transmitted first.
- `tx_datak`  out  LANESNUMBER*MAXPIPEWIDTH/8  per-byte K flags.
- `tx_datavalid`  out  LANESNUMBER  lane carries a stripe this cycle.
- `busy`  out  1  buffer non-empty or end pending.
- `lane_reverse`  in  1  only present with `TX_LANE_REVERSAL_EN`.

## Operation
- Stripe size S = L*W bytes, where L is the number of active lanes and W is the bytes per lane.
- Stripe byte k goes to logical lane k mod L, at lane byte position k/L.
- Configuration:
  - L and W are latched from `lanes_sel`/`width_sel` only while the buffer count is 0 and no end is pending.
  - Otherwise the latched values hold.
  - Reset values: L = 1, W = 1.
- Acceptance:
  - A beat is accepted when `in_valid && in_ready`.
  - `in_ready` = (count <= DEPTH-IN_BYTES), combinational from the registered count.
  - Accepted bytes are appended in order.
- Emission on each edge:
  - If count >= S, pop S bytes and drive lanes 0..L-1 with `tx_datavalid`=1.
  - Else if an end is pending and 0 < count < S, pop all count bytes and fill the rest of the stripe with data 0xF7, K=1. Clear pending, so count becomes 0.
  - Else if an end is pending and count = 0, clear pending and emit nothing.
  - Else emit nothing: every `tx_datavalid`=0, data 0, K 0.
- Count update on a simultaneous push and pop: count_next = count + pushed − popped. The pop decision uses the pre-edge count.
- `in_end` accepted together with bytes sets pending after the push. The pad stripe therefore follows after all full stripes have drained.
- A beat with `in_count`=0 is legal and adds no bytes; its `in_end` is still honoured.
- Lanes >= L, and bytes >= W within an active lane: data 0, K 0, valid 0.
- Count width is clog2(DEPTH+1); it never exceeds DEPTH.

## Timing
- All outputs are registered.
- A byte accepted at edge N appears on `tx_data` after edge N+1 at the earliest, provided its stripe is complete at N+1.
- Throughput: one stripe per cycle. With S = IN_BYTES and full beats, there is no stall.
- Reset values:
  - `tx_data`, `tx_datak`, `tx_datavalid`: 0.
  - `busy`: 0.
  - `in_ready`: 1.
  - Buffer count 0, pending end 0.
- Reset asserted mid-transfer discards buffer contents and the pending end immediately.

## Configuration
- `TX_LANE_REVERSAL_EN` defined:
  - Adds `lane_reverse`, sampled with the L/W latch.
  - When 1, logical lane i drives physical lane L-1-i.
- Undefined: the port is absent and the mapping is the identity.

## Test plan
- Default parameters, x16, width 4, two beats of 64 bytes with values 0..127 and `in_end` on the second:
  - After the edges accepting each beat, one stripe per cycle.
  - Lane 0 = {0x30,0x20,0x10,0x00} then {0x70,0x60,0x50,0x40}.
  - No pad stripe; `busy` returns to 0.
- x4, width 1, one beat with `in_count`=6 (0xA0..0xA5) and `in_end`:
  - Stripe 1: lanes 0..3 carry A0..A3.
  - Stripe 2: lanes 0..1 carry A4, A5; lanes 2..3 carry F7 with K=1.
  - Lanes 4..15 have `tx_datavalid`=0.
- Backpressure, x1, width 1, full beats held on `in_valid`:
  - `in_ready` deasserts once count > 64.
  - It reasserts when count falls back to 64.
  - No byte is lost or duplicated over 300 bytes.
- Change `lanes_sel` 4→2 while count = 40:
  - The output stays x16 until count reaches 0.
  - The next transfer is x4.
- Assert `reset_n`=0 with count = 70 and an end pending:
  - All outputs are 0 at once; `in_ready`=1.
  - After release the first new beat stripes from byte 0.
- With `TX_LANE_REVERSAL_EN`, x8, width 1, bytes 0..7, `lane_reverse`=1:
  - Physical lane 7 carries 0x00 and lane 0 carries 0x07.
